// File: rtl/cond_pkg.sv
// ============================================================================
// Module      : cond_pkg
// Description : Condition codes, external-condition base and flag bit indices
//               shared by the branch condition unit and its evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_pkg;

    localparam logic [3:0] EQ = 4'd0;
    localparam logic [3:0] NE = 4'd1;
    localparam logic [3:0] CS = 4'd2;
    localparam logic [3:0] CC = 4'd3;
    localparam logic [3:0] MI = 4'd4;
    localparam logic [3:0] PL = 4'd5;
    localparam logic [3:0] VS = 4'd6;
    localparam logic [3:0] VC = 4'd7;
    localparam logic [3:0] HI = 4'd8;
    localparam logic [3:0] LS = 4'd9;
    localparam logic [3:0] GE = 4'd10;
    localparam logic [3:0] LT = 4'd11;
    localparam logic [3:0] GT = 4'd12;
    localparam logic [3:0] LE = 4'd13;
    localparam logic [3:0] AL = 4'd14;
    localparam logic [3:0] NV = 4'd15;

    localparam int EXT_BASE = 16;

    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
// Module      : cond_eval
// Description : Combinational condition evaluator: code + flags + external
//               conditions to a result bit and an out-of-range indication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval
    import cond_pkg::*;
#(
    parameter int SEL_W   = 5,
    parameter int NUM_EXT = 4
) (
    input  logic [3:0]         flags,
    input  logic [NUM_EXT-1:0] ext_cond,
    input  logic [SEL_W-1:0]   cond_sel,
    output logic               result,
    output logic               illegal
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[N];
    assign w_z = flags[Z];
    assign w_c = flags[C];
    assign w_v = flags[V];

    always_comb begin
        result  = 1'b0;
        illegal = 1'b0;
        if (int'(cond_sel) < EXT_BASE) begin
            case (cond_sel[3:0])
                EQ:      result = w_z;
                NE:      result = !w_z;
                CS:      result = w_c;
                CC:      result = !w_c;
                MI:      result = w_n;
                PL:      result = !w_n;
                VS:      result = w_v;
                VC:      result = !w_v;
                HI:      result = w_c & !w_z;
                LS:      result = !w_c | w_z;
                GE:      result = (w_n == w_v);
                LT:      result = (w_n != w_v);
                GT:      result = !w_z & (w_n == w_v);
                LE:      result = w_z | (w_n != w_v);
                AL:      result = 1'b1;
                default: result = 1'b0;
            endcase
        end else if (int'(cond_sel) < EXT_BASE + NUM_EXT) begin
            // Compare against each legal external code to avoid an oversized index.
            for (int i = 0; i < NUM_EXT; i++) begin
                if (cond_sel == SEL_W'(EXT_BASE + i)) begin
                    result = ext_cond[i];
                end
            end
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_cond_unit.sv
// ============================================================================
// Module      : branch_cond_unit
// Description : Flag register plus one-cycle registered branch condition
//               evaluation with stall hold. Define COND_FLAG_BYPASS_EN to
//               evaluate against flags_in when a flag write coincides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond_unit
    import cond_pkg::*;
#(
    parameter int SEL_W   = 5,
    parameter int NUM_EXT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         flags_in,
    input  logic               flags_we,
    input  logic [NUM_EXT-1:0] ext_cond,
    input  logic [SEL_W-1:0]   cond_sel,
    input  logic               eval_valid,
    input  logic               stall,
    output logic               cond_out,
    output logic               cond_valid,
    output logic               cond_illegal,
    output logic [3:0]         flags_q
);

    logic [3:0] r_flags;
    logic       r_cond_out;
    logic       r_cond_valid;
    logic       r_cond_illegal;

    logic [3:0] w_eval_flags;
    logic       w_result;
    logic       w_illegal;

`ifdef COND_FLAG_BYPASS_EN
    assign w_eval_flags = flags_we ? flags_in : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    cond_eval #(
        .SEL_W   (SEL_W),
        .NUM_EXT (NUM_EXT)
    ) u_cond_eval (
        .flags    (w_eval_flags),
        .ext_cond (ext_cond),
        .cond_sel (cond_sel),
        .result   (w_result),
        .illegal  (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags        <= 4'b0000;
            r_cond_out     <= 1'b0;
            r_cond_valid   <= 1'b0;
            r_cond_illegal <= 1'b0;
        end else begin
            // Flag writes are independent of the evaluation pipeline stall.
            if (flags_we) begin
                r_flags <= flags_in;
            end
            if (!stall) begin
                r_cond_valid <= eval_valid;
                if (eval_valid) begin
                    r_cond_out     <= w_result;
                    r_cond_illegal <= w_illegal;
                end
            end
        end
    end

    assign cond_out     = r_cond_out;
    assign cond_valid   = r_cond_valid;
    assign cond_illegal = r_cond_illegal;
    assign flags_q      = r_flags;

endmodule

`default_nettype wire

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter SEL_W, default 5, meaning the condition-select width.
REQ-002 SHALL have parameter NUM_EXT, default 4, meaning the number of external condition inputs; legal range is 1 to 2**SEL_W-16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flags_in, input, 4 bits: ALU flags {N,Z,C,V}, with N as the MSB.
REQ-006 SHALL have port flags_we, input, 1 bit: flag register write enable.
REQ-007 SHALL have port ext_cond, input, NUM_EXT bits: external condition signals.
REQ-008 SHALL have port cond_sel, input, SEL_W bits: condition code.
REQ-009 SHALL have port eval_valid, input, 1 bit: an evaluation request is present.
REQ-010 SHALL have port stall, input, 1 bit: hold all outputs.
REQ-011 SHALL have port cond_out, output, 1 bit: registered condition result.
REQ-012 SHALL have port cond_valid, output, 1 bit: cond_out holds a fresh result.
REQ-013 SHALL have port cond_illegal, output, 1 bit: the last evaluated code was out of range.
REQ-014 SHALL have port flags_q, output, 4 bits: current flag register contents.

Function
REQ-015 SHALL load flags_q from flags_in on a rising edge when flags_we=1, regardless of stall.
REQ-016 SHALL evaluate codes 0-15 against the flags as EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, NV 0.
REQ-017 SHALL map codes 16..16+NUM_EXT-1 to ext_cond[code-16], sampled in the request cycle.
REQ-018 SHALL treat codes at or above 16+NUM_EXT as illegal: the result is 0 and cond_illegal=1.
REQ-019 SHALL have a latency of one cycle: when eval_valid=1 and stall=0 at edge k, cond_out, cond_illegal and cond_valid=1 appear after edge k.
REQ-020 SHALL, when eval_valid=0 and stall=0, clear cond_valid at the next edge and leave cond_out and cond_illegal unchanged.
REQ-021 SHALL, when stall=1, hold cond_out, cond_valid and cond_illegal unchanged and ignore eval_valid; the request is dropped, and the upstream stage re-presents it.
REQ-022 SHALL allow back-to-back requests, producing one result per cycle with no bubbles.
REQ-023 SHALL select flags when flags_we and eval_valid coincide according to REQ-029/REQ-030.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, set flags_q=4'b0000, cond_out=0, cond_valid=0 and cond_illegal=0.
REQ-025 SHALL give reset priority over flags_we, eval_valid and stall.
REQ-026 SHALL discard any request in flight during reset; no result appears after reset deasserts.
REQ-027 SHALL evaluate a request presented in the first cycle after reset deasserts normally, against the zero flags.

Configuration
REQ-028 SHALL compile flag forwarding in or out with the macro COND_FLAG_BYPASS_EN.
REQ-029 SHALL, with COND_FLAG_BYPASS_EN defined, evaluate against flags_in (not flags_q) when flags_we=1 in the request cycle.
REQ-030 SHALL, without COND_FLAG_BYPASS_EN, always evaluate against flags_q, i.e. the pre-write value.

Structure
REQ-031 SHALL place in the shared package cond_pkg: the condition code constants (EQ..NV = 0..15), EXT_BASE=16, and the flag bit indices N=3, Z=2, C=1, V=0.
REQ-032 SHALL implement the combinational evaluator (codes, flags and ext_cond to result and illegal) as sub-module cond_eval; branch_cond_unit holds only the registers, forwarding and stall logic.

Verification
REQ-033 SHALL cover: flags_we with flags_in=4'b0100, then cond_sel=0 (EQ) with eval_valid -> one cycle later cond_out=1, cond_valid=1; cond_sel=1 (NE) -> cond_out=0.
REQ-034 SHALL cover: flags N=1,V=0, then codes 10, 11, 12, 13 back-to-back -> cond_out sequence 0,1,0,1 on consecutive cycles, with cond_valid held at 1.
REQ-035 SHALL cover: ext_cond=4'b1000, cond_sel=19 -> cond_out=1; cond_sel=20 (SEL_W=5, NUM_EXT=4) -> cond_out=0 and cond_illegal=1.
REQ-036 SHALL cover: a request, then stall=1 for 3 cycles with a new eval_valid -> outputs unchanged for 3 cycles; after stall drops, cond_valid=0 unless the request is re-presented.
REQ-037 SHALL cover: flags_q=0, then flags_we with flags_in=4'b0100 plus eval EQ in the same cycle -> cond_out=1 with COND_FLAG_BYPASS_EN defined, 0 without.
REQ-038 SHALL cover: reset asserted in the cycle after a request -> cond_valid=0, cond_out=0 and flags_q=0 after that edge; no late result appears.
